// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station: label/opcode widths,
// the reserved "value ready" label, opcode constants and the entry-state enum.
package reservation_station_pkg;

  localparam int LABEL_W = 4;
  localparam int OP_W    = 6;

  // Label 0 means "operand value is present"; it is never allocated to an entry.
  localparam logic [LABEL_W-1:0] LABEL_NONE = '0;

  localparam logic [OP_W-1:0] opADD = 6'h00;
  localparam logic [OP_W-1:0] opSUB = 6'h01;
  localparam logic [OP_W-1:0] opAND = 6'h02;
  localparam logic [OP_W-1:0] opOR  = 6'h03;
  localparam logic [OP_W-1:0] opSLT = 6'h04;
  localparam logic [OP_W-1:0] opLW  = 6'h10;
  localparam logic [OP_W-1:0] opSW  = 6'h11;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    EXEC  = 2'd3
  } entryState_t;

endpackage

// File: rtl/reservation_station_rs_entry.sv
// One reservation-station entry: its lifecycle state, captured opcode and
// operands, and the CDB compare logic that resolves pending operands.
module rs_entry #(
  parameter int                 LABEL_W   = 4,
  parameter int                 DATA_W    = 32,
  parameter int                 OP_W      = 6,
  parameter logic [LABEL_W-1:0] OWN_LABEL = 1
) (
  input  logic                                 clk,
  input  logic                                 nRST,
  input  logic                                 load,
  input  logic [OP_W-1:0]                      issueOp,
  input  logic [DATA_W-1:0]                    issueData1,
  input  logic [DATA_W-1:0]                    issueData2,
  input  logic [LABEL_W-1:0]                   issueLabel1,
  input  logic [LABEL_W-1:0]                   issueLabel2,
  input  logic                                 bcEn,
  input  logic [LABEL_W-1:0]                   bcLabel,
  input  logic [DATA_W-1:0]                    bcData,
  input  logic                                 dispatch,
  output reservation_station_pkg::entryState_t state,
  output logic [OP_W-1:0]                      op,
  output logic [DATA_W-1:0]                    opA,
  output logic [DATA_W-1:0]                    opB
);
  import reservation_station_pkg::*;

  logic [LABEL_W-1:0] label1, label2;
  logic               hit1, hit2, fwd1, fwd2, ownHit;
  logic [LABEL_W-1:0] loadLabel1, loadLabel2;
  logic               resolved;

  // A zero label never matches, so label 0 on the bus cannot clear anything.
  assign hit1   = bcEn && (label1 != '0) && (label1 == bcLabel);
  assign hit2   = bcEn && (label2 != '0) && (label2 == bcLabel);
  assign fwd1   = bcEn && (issueLabel1 != '0) && (issueLabel1 == bcLabel);
  assign fwd2   = bcEn && (issueLabel2 != '0) && (issueLabel2 == bcLabel);
  assign ownHit = bcEn && (bcLabel == OWN_LABEL);

  assign loadLabel1 = fwd1 ? '0 : issueLabel1;
  assign loadLabel2 = fwd2 ? '0 : issueLabel2;
  assign resolved   = ((label1 == '0) || hit1) && ((label2 == '0) || hit2);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state  <= FREE;
      op     <= '0;
      opA    <= '0;
      opB    <= '0;
      label1 <= '0;
      label2 <= '0;
    end else begin
      case (state)
        FREE: begin
          if (load) begin
            op     <= issueOp;
            opA    <= fwd1 ? bcData : issueData1;
            opB    <= fwd2 ? bcData : issueData2;
            label1 <= loadLabel1;
            label2 <= loadLabel2;
            state  <= ((loadLabel1 == '0) && (loadLabel2 == '0)) ? READY : WAIT;
          end
        end
        WAIT: begin
          if (hit1) begin
            opA    <= bcData;
            label1 <= '0;
          end
          if (hit2) begin
            opB    <= bcData;
            label2 <= '0;
          end
          if (resolved) state <= READY;
        end
        READY: begin
          if (dispatch) state <= EXEC;
        end
        EXEC: begin
          // Held until our own result appears on the CDB, so the label stays reserved.
          if (ownHit) state <= FREE;
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: allocates the lowest FREE entry on issue and
// offers the lowest READY entry to the functional unit, locked while stalled.
module reservation_station #(
  parameter int ENTRIES    = 3,
  parameter int LABEL_BASE = 1,
  parameter int LABEL_W    = 4,
  parameter int DATA_W     = 32,
  parameter int OP_W       = 6
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 issue_valid,
  input  logic [OP_W-1:0]      issue_op,
  input  logic [DATA_W-1:0]    issue_data1,
  input  logic [DATA_W-1:0]    issue_data2,
  input  logic [LABEL_W-1:0]   issue_label1,
  input  logic [LABEL_W-1:0]   issue_label2,
  output logic [LABEL_W-1:0]   free_label,
  output logic                 full,
  input  logic                 bc_en,
  input  logic [LABEL_W-1:0]   bc_label,
  input  logic [DATA_W-1:0]    bc_data,
  output logic                 fu_valid,
  input  logic                 fu_ready,
  output logic [OP_W-1:0]      fu_op,
  output logic [DATA_W-1:0]    fu_a,
  output logic [DATA_W-1:0]    fu_b,
  output logic [LABEL_W-1:0]   fu_label,
  output logic [2*ENTRIES-1:0] dbgState
);
  import reservation_station_pkg::*;

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  entryState_t         entState [ENTRIES];
  logic [OP_W-1:0]     entOp    [ENTRIES];
  logic [DATA_W-1:0]   entA     [ENTRIES];
  logic [DATA_W-1:0]   entB     [ENTRIES];
  logic [ENTRIES-1:0]  load, dispatch;

  logic                anyFree, anyReady;
  logic [IDX_W-1:0]    freeIdx, readyIdx, selIdx;
  logic                lockValid;
  logic [IDX_W-1:0]    lockIdx;

  // Priority encoders: scanning downward leaves the lowest matching index.
  always_comb begin
    anyFree  = 1'b0;
    anyReady = 1'b0;
    freeIdx  = '0;
    readyIdx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entState[i] == FREE) begin
        anyFree = 1'b1;
        freeIdx = IDX_W'(i);
      end
      if (entState[i] == READY) begin
        anyReady = 1'b1;
        readyIdx = IDX_W'(i);
      end
    end
  end

  // A stalled offer stays on the same entry even if a lower-index one becomes READY.
  assign selIdx     = lockValid ? lockIdx : readyIdx;
  assign fu_valid   = anyReady;
  assign full       = !anyFree;
  assign free_label = anyFree ? (LABEL_W'(LABEL_BASE) + LABEL_W'(freeIdx)) : '0;

  always_comb begin
    fu_op    = '0;
    fu_a     = '0;
    fu_b     = '0;
    fu_label = '0;
    if (anyReady) begin
      fu_op    = entOp[selIdx];
      fu_a     = entA[selIdx];
      fu_b     = entB[selIdx];
      fu_label = LABEL_W'(LABEL_BASE) + LABEL_W'(selIdx);
    end
  end

  always_comb begin
    load     = '0;
    dispatch = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      load[i]     = issue_valid && anyFree && (freeIdx == IDX_W'(i));
      dispatch[i] = fu_valid && fu_ready && (selIdx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      lockValid <= 1'b0;
      lockIdx   <= '0;
    end else begin
      lockValid <= fu_valid && !fu_ready;
      lockIdx   <= selIdx;
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : gEntry
    rs_entry #(
      .LABEL_W   (LABEL_W),
      .DATA_W    (DATA_W),
      .OP_W      (OP_W),
      .OWN_LABEL (LABEL_W'(LABEL_BASE + g))
    ) uEntry (
      .clk         (clk),
      .nRST        (nRST),
      .load        (load[g]),
      .issueOp     (issue_op),
      .issueData1  (issue_data1),
      .issueData2  (issue_data2),
      .issueLabel1 (issue_label1),
      .issueLabel2 (issue_label2),
      .bcEn        (bc_en),
      .bcLabel     (bc_label),
      .bcData      (bc_data),
      .dispatch    (dispatch[g]),
      .state       (entState[g]),
      .op          (entOp[g]),
      .opA         (entA[g]),
      .opB         (entB[g])
    );
    assign dbgState[2*g +: 2] = entState[g];
  end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios followed by random traffic,
// every cycle compared against a queue-of-slots reference model.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int NE = 3;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int OW = 6;

  logic          clk = 1'b0;
  logic          nRST;
  logic          issue_valid;
  logic [OW-1:0] issue_op;
  logic [DW-1:0] issue_data1, issue_data2;
  logic [LW-1:0] issue_label1, issue_label2;
  logic [LW-1:0] free_label;
  logic          full;
  logic          bc_en;
  logic [LW-1:0] bc_label;
  logic [DW-1:0] bc_data;
  logic          fu_valid, fu_ready;
  logic [OW-1:0] fu_op;
  logic [DW-1:0] fu_a, fu_b;
  logic [LW-1:0] fu_label;
  logic [2*NE-1:0] dbgState;

  reservation_station #(
    .ENTRIES(NE), .LABEL_BASE(1), .LABEL_W(LW), .DATA_W(DW), .OP_W(OW)
  ) dut (
    .clk(clk), .nRST(nRST),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_data1(issue_data1), .issue_data2(issue_data2),
    .issue_label1(issue_label1), .issue_label2(issue_label2),
    .free_label(free_label), .full(full),
    .bc_en(bc_en), .bc_label(bc_label), .bc_data(bc_data),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_op(fu_op),
    .fu_a(fu_a), .fu_b(fu_b), .fu_label(fu_label),
    .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Reference model: slot i owns label i+1.
  entryState_t   mSt [NE];
  logic [LW-1:0] mL1 [NE], mL2 [NE];
  logic [DW-1:0] mA  [NE], mB  [NE];
  logic [OW-1:0] mOp [NE];
  bit            mStall;
  int            mHeld;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int lowestFree();
    for (int i = 0; i < NE; i++) if (mSt[i] == FREE) return i;
    return -1;
  endfunction

  function automatic int lowestReady();
    for (int i = 0; i < NE; i++) if (mSt[i] == READY) return i;
    return -1;
  endfunction

  function automatic int offered();
    if (mStall) return mHeld;
    return lowestReady();
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NE; i++) begin
      mSt[i] = FREE; mL1[i] = '0; mL2[i] = '0; mA[i] = '0; mB[i] = '0; mOp[i] = '0;
    end
    mStall = 0;
    mHeld  = -1;
  endtask

  // Applies one clock edge's worth of issue/snoop/dispatch/release to the model.
  task automatic modelEdge();
    int off, fr;
    entryState_t nSt [NE];
    off = offered();
    fr  = lowestFree();
    for (int e = 0; e < NE; e++) begin
      nSt[e] = mSt[e];
      if (mSt[e] == FREE && issue_valid && e == fr) begin
        mOp[e] = issue_op;
        if (bc_en && issue_label1 != 0 && issue_label1 == bc_label) begin
          mA[e] = bc_data; mL1[e] = '0;
        end else begin
          mA[e] = issue_data1; mL1[e] = issue_label1;
        end
        if (bc_en && issue_label2 != 0 && issue_label2 == bc_label) begin
          mB[e] = bc_data; mL2[e] = '0;
        end else begin
          mB[e] = issue_data2; mL2[e] = issue_label2;
        end
        nSt[e] = (mL1[e] == 0 && mL2[e] == 0) ? READY : WAIT;
      end else if (mSt[e] == WAIT) begin
        if (bc_en && mL1[e] != 0 && mL1[e] == bc_label) begin mA[e] = bc_data; mL1[e] = '0; end
        if (bc_en && mL2[e] != 0 && mL2[e] == bc_label) begin mB[e] = bc_data; mL2[e] = '0; end
        if (mL1[e] == 0 && mL2[e] == 0) nSt[e] = READY;
      end else if (mSt[e] == READY && e == off && fu_ready) begin
        nSt[e] = EXEC;
      end else if (mSt[e] == EXEC && bc_en && int'(bc_label) == e + 1) begin
        nSt[e] = FREE;
      end
    end
    mStall = (off >= 0) && !fu_ready;
    mHeld  = off;
    for (int e = 0; e < NE; e++) mSt[e] = nSt[e];
  endtask

  task automatic checkAll(input string tag);
    int fr, off;
    fr  = lowestFree();
    off = offered();
    chk($sformatf("%s.full", tag), full, (fr < 0));
    chk($sformatf("%s.free_label", tag), free_label, (fr < 0) ? 0 : fr + 1);
    chk($sformatf("%s.fu_valid", tag), fu_valid, (off >= 0));
    if (off >= 0) begin
      chk($sformatf("%s.fu_op", tag), fu_op, mOp[off]);
      chk($sformatf("%s.fu_a", tag), fu_a, mA[off]);
      chk($sformatf("%s.fu_b", tag), fu_b, mB[off]);
      chk($sformatf("%s.fu_label", tag), fu_label, off + 1);
    end
    for (int e = 0; e < NE; e++)
      chk($sformatf("%s.state%0d", tag, e), dbgState[2*e +: 2], mSt[e]);
  endtask

  task automatic tick(input string tag);
    modelEdge();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic idle();
    issue_valid = 0; issue_op = '0; issue_data1 = '0; issue_data2 = '0;
    issue_label1 = '0; issue_label2 = '0;
    bc_en = 0; bc_label = '0; bc_data = '0; fu_ready = 0;
  endtask

  task automatic issue(input logic [OW-1:0] op, input logic [DW-1:0] d1, input logic [LW-1:0] l1,
                       input logic [DW-1:0] d2, input logic [LW-1:0] l2);
    issue_valid = 1; issue_op = op;
    issue_data1 = d1; issue_label1 = l1;
    issue_data2 = d2; issue_label2 = l2;
  endtask

  task automatic bcast(input logic [LW-1:0] lbl, input logic [DW-1:0] d);
    bc_en = 1; bc_label = lbl; bc_data = d;
  endtask

  initial begin
    idle();
    nRST = 0;
    modelReset();
    #12;
    chk("reset.free_label", free_label, 1);
    chk("reset.full", full, 0);
    chk("reset.fu_valid", fu_valid, 0);
    chk("reset.fu_op", fu_op, 0);
    chk("reset.fu_a", fu_a, 0);
    chk("reset.fu_b", fu_b, 0);
    chk("reset.fu_label", fu_label, 0);
    nRST = 1;
    @(posedge clk);
    #1;
    checkAll("reset");

    // Ready issue, dispatch, release by own broadcast
    issue(opADD, 5, 0, 7, 0);
    tick("rdy_issue");
    chk("rdy.fu_valid", fu_valid, 1);
    chk("rdy.fu_a", fu_a, 5);
    chk("rdy.fu_b", fu_b, 7);
    chk("rdy.fu_label", fu_label, 1);
    idle(); fu_ready = 1;
    tick("rdy_disp");
    chk("rdy.disp_state", dbgState[1:0], EXEC);
    idle(); bcast(1, 32'h12);
    tick("rdy_rel");
    chk("rdy.rel_free_label", free_label, 1);

    // Pending operand resolved by snoop
    idle(); issue(opSUB, 0, 2, 9, 0);
    tick("pend_issue");
    chk("pend.no_valid", fu_valid, 0);
    idle(); bcast(2, 32'h1234);
    tick("pend_snoop");
    chk("pend.fu_valid", fu_valid, 1);
    chk("pend.fu_a", fu_a, 32'h1234);
    chk("pend.fu_b", fu_b, 9);
    idle(); fu_ready = 1;
    tick("pend_disp");
    idle(); bcast(1, 0);
    tick("pend_rel");

    // Issue-cycle forwarding
    idle(); issue(opAND, 11, 0, 0, 3); bcast(3, 42);
    tick("fwd_issue");
    chk("fwd.fu_valid", fu_valid, 1);
    chk("fwd.fu_b", fu_b, 42);
    idle(); fu_ready = 1;
    tick("fwd_disp");
    idle(); bcast(1, 0);
    tick("fwd_rel");

    // Fill, then a dropped fourth issue
    for (int i = 0; i < NE; i++) begin
      idle(); issue(opOR, 100 + i, LW'(8 + i), 200 + i, 0);
      tick("full_fill");
    end
    chk("full.full", full, 1);
    chk("full.free_label", free_label, 0);
    idle(); issue(opSW, 32'h77, 0, 32'h88, 0);
    tick("full_drop");
    chk("full.drop_no_valid", fu_valid, 0);
    for (int i = 0; i < NE; i++) begin
      idle(); bcast(LW'(8 + i), 32'h500 + i);
      tick("full_resolve");
    end
    for (int i = 0; i < NE; i++) begin
      idle(); fu_ready = 1;
      tick("full_disp");
    end
    chk("full.no_fourth", fu_valid, 0);
    for (int i = 0; i < NE; i++) begin
      idle(); bcast(LW'(1 + i), 0);
      tick("full_rel");
    end

    // Backpressure: offer held, own-label broadcast while READY ignored
    idle(); issue(opSLT, 32'hAA, 0, 32'hBB, 0);
    tick("bp_issue");
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i == 1) bcast(1, 0);
      if (i == 2) issue(opLW, 1, 0, 2, 0);
      tick("bp_stall");
      chk("bp.fu_a", fu_a, 32'hAA);
      chk("bp.fu_label", fu_label, 1);
      chk("bp.not_exec", dbgState[1:0], READY);
    end
    idle(); fu_ready = 1;
    tick("bp_disp");
    idle(); fu_ready = 1;
    tick("bp_disp2");
    idle(); bcast(1, 0);
    tick("bp_rel1");
    idle(); bcast(2, 0);
    tick("bp_rel2");

    // Reset mid-operation: one WAIT, one EXEC
    idle(); issue(opADD, 0, 9, 3, 0);
    tick("rst_wait");
    idle(); issue(opADD, 4, 0, 5, 0);
    tick("rst_rdy");
    idle(); fu_ready = 1;
    tick("rst_exec");
    idle();
    #1;
    nRST = 0;
    #1;
    modelReset();
    chk("rst.full", full, 0);
    chk("rst.fu_valid", fu_valid, 0);
    chk("rst.free_label", free_label, 1);
    #1;
    nRST = 1;
    @(posedge clk);
    #1;
    checkAll("rst_after");

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        issue(OW'($urandom), $urandom, ($urandom_range(0, 1) == 1) ? LW'($urandom_range(1, 7)) : '0,
              $urandom, ($urandom_range(0, 1) == 1) ? LW'($urandom_range(1, 7)) : '0);
      if ($urandom_range(0, 1) == 1) bcast(LW'($urandom_range(0, 7)), $urandom);
      fu_ready = ($urandom_range(0, 9) < 6);
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
